// File: rtl/seg14_scan_driver.sv
// seg14_scan_driver: 12-digit 14-segment pad driver with dead-time blanking and optional PWM dimming (SEG14_PWM_DIM_EN)
module seg14_scan_driver #(
    parameter int DEAD_CYCLES = 2,
    parameter int PWM_BITS    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [11:0]         sel_in,
    input  logic [13:0]         segm_in,
    input  logic [PWM_BITS-1:0] bright,
    output logic [11:0]         sel_out,
    output logic [13:0]         segm_out,
    output logic                sel_err
);
    typedef enum logic [1:0] {OFF, BLANK, ON} state_t;
    state_t      state, state_d;
    logic [3:0]  dead_cnt, dead_d;
    logic [11:0] sel_q, sel_d;
    logic [13:0] segm_q, segm_d;
    logic        q_hot, in_bad, lit;
    assign q_hot  = (sel_q != '0) && ((sel_q & (sel_q - 12'd1)) == '0);
    assign in_bad = (sel_in == '0) || ((sel_in & (sel_in - 12'd1)) != '0);
`ifdef SEG14_PWM_DIM_EN
    logic [PWM_BITS-1:0] pwm_cnt;
    // free-running brightness phase counter
    always_ff @(posedge clk or posedge rst)
        if (rst) pwm_cnt <= '0;
        else     pwm_cnt <= pwm_cnt + 1'b1;
    assign lit = (pwm_cnt < bright) || (&bright);
`else
    logic unused_bright;
    assign unused_bright = ^bright;
    assign lit = 1'b1;
`endif
    // state, counter, input capture and output registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= OFF;
            dead_cnt <= '0;
            sel_q    <= '0;
            segm_q   <= '0;
            sel_out  <= '0;
            segm_out <= '0;
            sel_err  <= 1'b0;
        end else begin
            state    <= state_d;
            dead_cnt <= dead_d;
            sel_q    <= sel_in;
            segm_q   <= segm_in;
            sel_out  <= sel_d;
            segm_out <= segm_d;
            sel_err  <= sel_err | in_bad;
        end
    // next state: disable wins, then any digit change (or wake-up) restarts blanking
    always_comb begin
        state_d = state;
        dead_d  = dead_cnt;
        if (!enable)
            state_d = OFF;
        else if (state == OFF || sel_in != sel_q) begin
            state_d = BLANK;
            dead_d  = 4'(DEAD_CYCLES);
        end else if (state == BLANK) begin
            dead_d  = dead_cnt - 4'd1;
            state_d = (dead_cnt == 4'd1) ? ON : BLANK;
        end
    end
    // pad drive for the coming cycle: dark unless lighting a valid one-hot digit
    always_comb begin
        sel_d  = (state_d == ON && q_hot) ? sel_q : '0;
        segm_d = (state_d == ON && q_hot && lit) ? segm_q : '0;
    end
endmodule

// File: tb/tb_seg14_scan_driver.sv
// tb_seg14_scan_driver: randomized check of seg14_scan_driver against an input-history reference model
module tb_seg14_scan_driver;
    localparam int D = 2;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] sel_in = '0;
    logic [13:0] segm_in = '0;
    logic [3:0]  bright = '0;
    logic [11:0] sel_out;
    logic [13:0] segm_out;
    logic        sel_err;
    int total = 0;
    int bad = 0;
    int n = 0;
    bit err_m = 1'b0;
    bit          en_h [0:4095];
    logic [11:0] s_h  [0:4095];
    logic [13:0] g_h  [0:4095];
    logic [3:0]  b_h  [0:4095];

    seg14_scan_driver #(.DEAD_CYCLES(D), .PWM_BITS(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sel_in(sel_in), .segm_in(segm_in),
        .bright(bright), .sel_out(sel_out), .segm_out(segm_out), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // a digit is shown at edge n only if enable was sampled high on the last D+1 edges
    // and sel_in held still over the last D of them
    function automatic bit shown(input int k);
        if (k - D < 1) return 1'b0;
        for (int j = k - D; j <= k; j++) if (!en_h[j]) return 1'b0;
        for (int j = k - D + 1; j <= k; j++) if (s_h[j] != s_h[j-1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step(input bit e, input logic [11:0] s, input logic [13:0] g, input logic [3:0] b);
        bit on, hot, lit;
        @(negedge clk);
        enable = e; sel_in = s; segm_in = g; bright = b;
        @(posedge clk);
        n++;
        en_h[n] = e; s_h[n] = s; g_h[n] = g; b_h[n] = b;
        if ($countones(s) != 1) err_m = 1'b1;
        #1;
        on  = shown(n);
        hot = ($countones(s_h[n-1]) == 1);
`ifdef SEG14_PWM_DIM_EN
        lit = (b == 4'hF) || (((n - 1) % 16) < int'(b));
`else
        lit = 1'b1;
`endif
        check("sel_out", 32'(sel_out), (on && hot) ? 32'(s_h[n-1]) : 32'd0);
        check("segm_out", 32'(segm_out), (on && hot && lit) ? 32'(g_h[n-1]) : 32'd0);
        check("sel_err", 32'(sel_err), 32'(err_m));
    endtask

    task automatic do_reset();
        #3 rst = 1'b1;
        #1;
        check("rst_sel", 32'(sel_out), 32'd0);
        check("rst_segm", 32'(segm_out), 32'd0);
        check("rst_err", 32'(sel_err), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        n = 0;
        err_m = 1'b0;
        s_h[0] = '0;
        g_h[0] = '0;
        en_h[0] = 1'b0;
    endtask

    initial begin
        logic [11:0] s;
        int cnt, act;
        do_reset();
        // power-up sequence: two dark edges, then digit 0 lit
        step(1, 12'h001, 14'h3F00, 4'hF); check("up1", 32'(sel_out), 32'd0);
        step(1, 12'h001, 14'h3F00, 4'hF); check("up2", 32'(segm_out), 32'd0);
        step(1, 12'h001, 14'h3F00, 4'hF); check("up3_sel", 32'(sel_out), 32'h001);
        check("up3_segm", 32'(segm_out), 32'h3F00);
        step(1, 12'h001, 14'h3F00, 4'hF); check("up4", 32'(sel_out), 32'h001);
        // segment-only change shows one edge after sampling, no blanking
        step(1, 12'h001, 14'h0155, 4'hF);
        step(1, 12'h001, 14'h0155, 4'hF); check("segchg", 32'(segm_out), 32'h0155);
        // digit change blanks for D edges
        step(1, 12'h002, 14'h0155, 4'hF); check("chg1", 32'(sel_out), 32'd0);
        step(1, 12'h002, 14'h0155, 4'hF); check("chg2", 32'(sel_out), 32'd0);
        step(1, 12'h002, 14'h0155, 4'hF); check("chg3", 32'(sel_out), 32'h002);
        // disable wins over simultaneous digit change
        step(0, 12'h004, 14'h0155, 4'hF); check("dis", 32'(sel_out), 32'd0);
        // non-one-hot select: dark, sticky error until reset
        do_reset();
        repeat (4) step(1, 12'h001, 14'h1234, 4'hF);
        step(1, 12'h003, 14'h1234, 4'hF);
        repeat (3) step(1, 12'h004, 14'h1234, 4'hF);
        check("err_sel", 32'(sel_out), 32'h004);
        check("err_hold", 32'(sel_err), 32'd1);
        // async reset mid-BLANK then mid-ON
        do_reset();
        step(1, 12'h001, 14'h3F00, 4'hF);
        do_reset();
        repeat (4) step(1, 12'h001, 14'h3F00, 4'hF);
        check("pre_rst_on", 32'(sel_out), 32'h001);
        do_reset();
        repeat (3) step(1, 12'h001, 14'h3F00, 4'hF);
        check("post_rst", 32'(segm_out), 32'h3F00);
`ifdef SEG14_PWM_DIM_EN
        cnt = 0; act = 0;
        repeat (16) begin
            step(1, 12'h001, 14'h3FFF, 4'd4);
            if (segm_out != '0) cnt++;
        end
        check("pwm4", 32'(cnt), 32'd4);
        cnt = 0;
        repeat (16) begin
            step(1, 12'h001, 14'h3FFF, 4'd0);
            if (segm_out != '0) cnt++;
            if (sel_out == 12'h001) act++;
        end
        check("pwm0_segm", 32'(cnt), 32'd0);
        check("pwm0_sel", 32'(act), 32'd16);
`else
        step(1, 12'h001, 14'h2AAA, 4'd0);
        step(1, 12'h001, 14'h2AAA, 4'd0);
        check("nodim", 32'(segm_out), 32'h2AAA);
`endif
        // randomized traffic with periodic resets
        do_reset();
        s = 12'h001;
        for (int i = 0; i < 1800; i++) begin
            if (i % 300 == 299) do_reset();
            if ($urandom_range(0, 3) == 0) s = 12'(1) << $urandom_range(0, 11);
            if ($urandom_range(0, 249) == 0) s = 12'($urandom);
            step($urandom_range(0, 24) != 0, s, 14'($urandom), 4'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
